// File: rtl/game_pkg.sv
// Shared definitions for the blackjack round sequencer.
//  - Default rule parameters (bust threshold, opening deal size, hand size limit)
//  - Turn FSM state encodings, exported on state_out for the display
//  - Result codes driven on the result port
//  - Card fetch sub-phase encoding
//  - Helper functions for the settle comparison and for saturating counters
package game_pkg;

  localparam logic [4:0] DEFAULT_TARGET     = 5'd21;
  localparam logic [3:0] DEFAULT_INIT_CARDS = 4'd2;
  localparam logic [3:0] DEFAULT_MAX_CARDS  = 4'd11;

  // Plain constants rather than an enum so the display side can decode
  // state_out with the same numbers without importing anything.
  localparam logic [2:0] ST_DEAL   = 3'd0;
  localparam logic [2:0] ST_PLAYER = 3'd1;
  localparam logic [2:0] ST_SLAVE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_SLAVE  = 2'b10,
    RES_PUSH   = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_FETCH = 2'd1,
    PH_READY = 2'd2,
    PH_WAIT  = 2'd3
  } fetch_phase_t;

  // A player bust loses outright, even if the slave also busted.
  function automatic result_t settle_result(input logic [4:0] p,
                                            input logic [4:0] s,
                                            input logic [4:0] target);
    result_t r;
    if (p > target)      r = RES_SLAVE;
    else if (s > target) r = RES_PLAYER;
    else if (p > s)      r = RES_PLAYER;
    else if (s > p)      r = RES_SLAVE;
    else                 r = RES_PUSH;
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/card_fetch.sv
// Single-card fetch engine used by the turn sequencer.
// Runs one card through four sub-phases: IDLE -> FETCH -> READY -> WAIT -> IDLE.
//  clock           in   system clock, posedge
//  new_Game        in   synchronous active-high reset; abandons any request in flight
//  start           in   begin a fetch (only honoured in IDLE)
//  target_player   in   destination of the card being started: 1 player, 0 slave
//  cardReq         out  request to deck, high for the whole FETCH phase
//  cardValid       in   deck presents cardValue this cycle (ignored outside FETCH)
//  cardValue       in   4-bit card value from deck, passed through unchanged
//  cardValueOut    out  registered card value for the hands
//  cardReadyPlayer out  one-cycle pulse in READY when the card belongs to the player
//  cardReadySlave  out  one-cycle pulse in READY when the card belongs to the slave
//  busy            out  a fetch is in progress (any phase other than IDLE)
//  done            out  high in WAIT; hand totals already include the new card
module card_fetch
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       new_Game,
  input  logic       start,
  input  logic       target_player,
  output logic       cardReq,
  input  logic       cardValid,
  input  logic [3:0] cardValue,
  output logic [3:0] cardValueOut,
  output logic       cardReadyPlayer,
  output logic       cardReadySlave,
  output logic       busy,
  output logic       done
);

  fetch_phase_t phase_q, phase_d;
  logic         target_q, target_d;
  logic [3:0]   value_q, value_d;

  // Phase sequencing. The destination is captured at start so the caller
  // can change its mind freely while the card is in flight. The WAIT phase
  // exists so the hand accumulators, which load on the READY pulse, have
  // settled before the sequencer looks at any total.
  always_comb begin
    phase_d  = phase_q;
    target_d = target_q;
    value_d  = value_q;
    unique case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d  = PH_FETCH;
          target_d = target_player;
        end
      end
      PH_FETCH: begin
        if (cardValid) begin
          value_d = cardValue;
          phase_d = PH_READY;
        end
      end
      PH_READY: phase_d = PH_WAIT;
      PH_WAIT:  phase_d = PH_IDLE;
      default:  phase_d = PH_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (new_Game) begin
      phase_q  <= PH_IDLE;
      target_q <= 1'b0;
      value_q  <= 4'd0;
    end else begin
      phase_q  <= phase_d;
      target_q <= target_d;
      value_q  <= value_d;
    end
  end

  assign cardReq         = (phase_q == PH_FETCH);
  assign cardValueOut    = value_q;
  assign cardReadyPlayer = (phase_q == PH_READY) &&  target_q;
  assign cardReadySlave  = (phase_q == PH_READY) && !target_q;
  assign busy            = (phase_q != PH_IDLE);
  assign done            = (phase_q == PH_WAIT);

endmodule

// File: rtl/game_turn_scheduler.sv
// Top-level sequencer for one blackjack round, human player versus slave hand.
// Deals the opening cards alternately (player first), runs the player turn,
// then the slave turn, settles the winner and holds the result until the next
// new_Game.
//  clock            in   system clock, posedge
//  new_Game         in   synchronous active-high reset, also starts a new round
//  hit, stand       in   player requests, single-cycle pulses
//  cardReq          out  request to deck, held until cardValid
//  cardValid        in   deck handshake
//  cardValue        in   4-bit card value from deck
//  cardValueOut     out  registered card value routed to the hands
//  cardReadyPlayer  out  one-cycle pulse, card is for the player
//  cardReadySlave   out  one-cycle pulse, card is for the slave
//  totalValuePlayer in   5-bit player hand total
//  totalValueSlave  in   5-bit slave hand total
//  finishSlave      in   slave hand declares itself done
//  state_out        out  turn FSM state (see game_pkg ST_*)
//  gameOver         out  high in DONE
//  result           out  00 none, 01 player wins, 10 slave wins, 11 push
module game_turn_scheduler
  import game_pkg::*;
#(
  parameter logic [3:0] INIT_CARDS = DEFAULT_INIT_CARDS,
  parameter logic [4:0] TARGET     = DEFAULT_TARGET,
  parameter logic [3:0] MAX_CARDS  = DEFAULT_MAX_CARDS
) (
  input  logic       clock,
  input  logic       new_Game,
  input  logic       hit,
  input  logic       stand,
  output logic       cardReq,
  input  logic       cardValid,
  input  logic [3:0] cardValue,
  output logic [3:0] cardValueOut,
  output logic       cardReadyPlayer,
  output logic       cardReadySlave,
  input  logic [4:0] totalValuePlayer,
  input  logic [4:0] totalValueSlave,
  input  logic       finishSlave,
  output logic [2:0] state_out,
  output logic       gameOver,
  output logic [1:0] result
);

  logic [2:0] state_q, state_d;
  logic [3:0] player_count_q, player_count_d;
  logic [3:0] slave_count_q, slave_count_d;
  result_t    result_q, result_d;

  logic fetch_start;
  logic fetch_to_player;
  logic fetch_busy;
  logic fetch_done;

  card_fetch u_card_fetch (
    .clock           (clock),
    .new_Game        (new_Game),
    .start           (fetch_start),
    .target_player   (fetch_to_player),
    .cardReq         (cardReq),
    .cardValid       (cardValid),
    .cardValue       (cardValue),
    .cardValueOut    (cardValueOut),
    .cardReadyPlayer (cardReadyPlayer),
    .cardReadySlave  (cardReadySlave),
    .busy            (fetch_busy),
    .done            (fetch_done)
  );

  // Turn FSM. Player and slave inputs are only looked at while the fetch
  // engine is idle, so hit/stand pulses during a fetch are simply dropped.
  // Totals are only judged on the fetch engine's done cycle, when the hand
  // accumulators already include the card. Card counters follow the ready
  // pulses so they are also current on the done cycle.
  always_comb begin
    state_d         = state_q;
    player_count_d  = player_count_q;
    slave_count_d   = slave_count_q;
    result_d        = result_q;
    fetch_start     = 1'b0;
    fetch_to_player = 1'b0;

    if (cardReadyPlayer) player_count_d = sat_inc(player_count_q);
    if (cardReadySlave)  slave_count_d  = sat_inc(slave_count_q);

    case (state_q)
      ST_DEAL: begin
        // Equal counts means it is the player's turn to receive a card,
        // which gives the P,S,P,S order. The slave always gets the last
        // opening card, so its count says when the deal is complete.
        if (!fetch_busy) begin
          if (slave_count_q >= INIT_CARDS) begin
            state_d = ST_PLAYER;
          end else begin
            fetch_start     = 1'b1;
            fetch_to_player = (player_count_q == slave_count_q);
          end
        end
      end
      ST_PLAYER: begin
        if (!fetch_busy) begin
          if (stand) begin
            state_d = ST_SLAVE;
          end else if (hit) begin
            fetch_start     = 1'b1;
            fetch_to_player = 1'b1;
          end
        end else if (fetch_done) begin
          if (totalValuePlayer > TARGET) begin
            state_d = ST_SETTLE;
          end else if ((totalValuePlayer == TARGET) ||
                       (player_count_q >= MAX_CARDS)) begin
            state_d = ST_SLAVE;
          end
        end
      end
      ST_SLAVE: begin
        if (!fetch_busy) begin
          if (finishSlave || (slave_count_q >= MAX_CARDS)) begin
            state_d = ST_SETTLE;
          end else begin
            fetch_start = 1'b1;
          end
        end else if (fetch_done && (slave_count_q >= MAX_CARDS)) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        result_d = settle_result(totalValuePlayer, totalValueSlave, TARGET);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_DEAL;
      end
    endcase
  end

  // State registers; new_Game outranks every other input.
  always_ff @(posedge clock) begin
    if (new_Game) begin
      state_q        <= ST_DEAL;
      player_count_q <= 4'd0;
      slave_count_q  <= 4'd0;
      result_q       <= RES_NONE;
    end else begin
      state_q        <= state_d;
      player_count_q <= player_count_d;
      slave_count_q  <= slave_count_d;
      result_q       <= result_d;
    end
  end

  assign state_out = state_q;
  assign gameOver  = (state_q == ST_DONE);
  assign result    = result_q;

endmodule
